// File: rtl/mrelbp_window_5x5_if.sv
// Pixel stream in, 5x5 neighbourhood out, for the MRELBP window generator.
// Signal names match the block's documented port list; o_state is the FSM debug view.
interface mrelbp_window_5x5_if #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);

    logic             i_sof;
    logic             i_pixel_valid;
    logic [WIDTH-1:0] i_pixel;

    logic [WIDTH-1:0] o_pixel_11, o_pixel_12, o_pixel_13, o_pixel_14, o_pixel_15;
    logic [WIDTH-1:0] o_pixel_21, o_pixel_22, o_pixel_23, o_pixel_24, o_pixel_25;
    logic [WIDTH-1:0] o_pixel_31, o_pixel_32, o_pixel_33, o_pixel_34, o_pixel_35;
    logic [WIDTH-1:0] o_pixel_41, o_pixel_42, o_pixel_43, o_pixel_44, o_pixel_45;
    logic [WIDTH-1:0] o_pixel_51, o_pixel_52, o_pixel_53, o_pixel_54, o_pixel_55;
    logic             o_window_valid;
    logic [RW-1:0]    o_center_row;
    logic [CW-1:0]    o_center_col;
    logic             o_frame_done;
    logic             o_state;

    modport slave (
        input  i_sof, i_pixel_valid, i_pixel,
        output o_pixel_11, o_pixel_12, o_pixel_13, o_pixel_14, o_pixel_15,
        output o_pixel_21, o_pixel_22, o_pixel_23, o_pixel_24, o_pixel_25,
        output o_pixel_31, o_pixel_32, o_pixel_33, o_pixel_34, o_pixel_35,
        output o_pixel_41, o_pixel_42, o_pixel_43, o_pixel_44, o_pixel_45,
        output o_pixel_51, o_pixel_52, o_pixel_53, o_pixel_54, o_pixel_55,
        output o_window_valid, o_center_row, o_center_col, o_frame_done, o_state
    );

    modport master (
        output i_sof, i_pixel_valid, i_pixel,
        input  o_pixel_11, o_pixel_12, o_pixel_13, o_pixel_14, o_pixel_15,
        input  o_pixel_21, o_pixel_22, o_pixel_23, o_pixel_24, o_pixel_25,
        input  o_pixel_31, o_pixel_32, o_pixel_33, o_pixel_34, o_pixel_35,
        input  o_pixel_41, o_pixel_42, o_pixel_43, o_pixel_44, o_pixel_45,
        input  o_pixel_51, o_pixel_52, o_pixel_53, o_pixel_54, o_pixel_55,
        input  o_window_valid, o_center_row, o_center_col, o_frame_done, o_state
    );
endinterface

// File: rtl/mrelbp_window_5x5.sv
// Streaming 5x5 neighbourhood generator: four line buffers feed a shifting 5x5
// register window that is flagged valid only where the full neighbourhood lies inside the frame.
module mrelbp_window_5x5 #(
    parameter int WIDTH = 8,
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input logic                i_clk,
    input logic                i_rst_n,
    mrelbp_window_5x5_if.slave bus
);
    localparam int RW = $clog2(IMG_H);
    localparam int CW = $clog2(IMG_W);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

    // Handshake: a pixel is taken on a rising edge where i_pixel_valid is high and the
    // block is ACTIVE or i_sof is high. There is no ready; the source is never stalled.
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    row_q, row_d, cur_row;
    logic [CW-1:0]    col_q, col_d, cur_col;
    logic             accept, last, win_ok;

    logic [WIDTH-1:0] lb0_mem [IMG_W];
    logic [WIDTH-1:0] lb1_mem [IMG_W];
    logic [WIDTH-1:0] lb2_mem [IMG_W];
    logic [WIDTH-1:0] lb3_mem [IMG_W];
    logic [WIDTH-1:0] col_new [5];

    logic [WIDTH-1:0] win_q [5][5];
    logic             valid_q, done_q;
    logic [RW-1:0]    crow_q;
    logic [CW-1:0]    ccol_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACTIVE;
            ACTIVE:  if (accept && last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (accept) begin
            if (last) begin
                row_d = '0;
                col_d = '0;
            end else if (cur_col == COL_LAST) begin
                row_d = cur_row + 1'b1;
                col_d = '0;
            end else begin
                row_d = cur_row;
                col_d = cur_col + 1'b1;
            end
        end
    end

    // A start-of-frame pixel always lands at (0,0), even mid-frame.
    always_comb begin
        accept  = 1'b0;
        cur_row = row_q;
        cur_col = col_q;
        if (bus.i_pixel_valid && (bus.i_sof || state_q == ACTIVE)) accept = 1'b1;
        if (bus.i_sof) begin
            cur_row = '0;
            cur_col = '0;
        end
        last   = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        win_ok = accept && (cur_row >= RW'(4)) && (cur_col >= CW'(4));
    end

    always_comb begin
        col_new[0] = lb3_mem[cur_col];
        col_new[1] = lb2_mem[cur_col];
        col_new[2] = lb1_mem[cur_col];
        col_new[3] = lb0_mem[cur_col];
        col_new[4] = bus.i_pixel;
    end

    // Line buffers are plain RAM; stale rows are masked by the row >= 4 gate.
    always_ff @(posedge i_clk) begin
        if (accept) begin
            lb3_mem[cur_col] <= lb2_mem[cur_col];
            lb2_mem[cur_col] <= lb1_mem[cur_col];
            lb1_mem[cur_col] <= lb0_mem[cur_col];
            lb0_mem[cur_col] <= bus.i_pixel;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < 5; i++)
                for (int j = 0; j < 5; j++)
                    win_q[i][j] <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            crow_q  <= '0;
            ccol_q  <= '0;
        end else begin
            valid_q <= win_ok;
            done_q  <= accept && last;
            if (accept) begin
                for (int i = 0; i < 5; i++) begin
                    for (int j = 0; j < 4; j++)
                        win_q[i][j] <= win_q[i][j+1];
                    win_q[i][4] <= col_new[i];
                end
            end
            if (win_ok) begin
                crow_q <= cur_row - RW'(2);
                ccol_q <= cur_col - CW'(2);
            end
        end
    end

    assign bus.o_pixel_11 = win_q[0][0];
    assign bus.o_pixel_12 = win_q[0][1];
    assign bus.o_pixel_13 = win_q[0][2];
    assign bus.o_pixel_14 = win_q[0][3];
    assign bus.o_pixel_15 = win_q[0][4];
    assign bus.o_pixel_21 = win_q[1][0];
    assign bus.o_pixel_22 = win_q[1][1];
    assign bus.o_pixel_23 = win_q[1][2];
    assign bus.o_pixel_24 = win_q[1][3];
    assign bus.o_pixel_25 = win_q[1][4];
    assign bus.o_pixel_31 = win_q[2][0];
    assign bus.o_pixel_32 = win_q[2][1];
    assign bus.o_pixel_33 = win_q[2][2];
    assign bus.o_pixel_34 = win_q[2][3];
    assign bus.o_pixel_35 = win_q[2][4];
    assign bus.o_pixel_41 = win_q[3][0];
    assign bus.o_pixel_42 = win_q[3][1];
    assign bus.o_pixel_43 = win_q[3][2];
    assign bus.o_pixel_44 = win_q[3][3];
    assign bus.o_pixel_45 = win_q[3][4];
    assign bus.o_pixel_51 = win_q[4][0];
    assign bus.o_pixel_52 = win_q[4][1];
    assign bus.o_pixel_53 = win_q[4][2];
    assign bus.o_pixel_54 = win_q[4][3];
    assign bus.o_pixel_55 = win_q[4][4];

    assign bus.o_window_valid = valid_q;
    assign bus.o_frame_done   = done_q;
    assign bus.o_center_row   = crow_q;
    assign bus.o_center_col   = ccol_q;
    assign bus.o_state        = (state_q == ACTIVE);
endmodule
